word_arith_host: RTL
====================

# word_arith_host

Self-checking host for the ReWire-generated word-arithmetic device, which computes f(x) = ((((x+1)**2) * (x-2)) / 3) % (x+1) in 8-bit wrapping arithmetic. The host sweeps an operand range and drives each operand on the device's `__in0`. For each operand it computes the expected result with its own multi-cycle shift/add multiplier and restoring divider. It then samples the device's `__out0` and `__continue` and tallies mismatches. It sits beside the device in regression and FPGA bring-up builds.

## Interface
- `W`, 8, operand/result width; all arithmetic wraps modulo 2^W.
- `clk` in 1: the only clock; rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse that launches a sweep; ignored while `busy`.
- `x_first` in W: first operand, sampled on `start`.
- `x_last` in W: last operand (inclusive), sampled on `start`.
- `dut_in` out W: drives device `__in0`.
- `dut_out` in W: from device `__out0`.
- `dut_cont` in 1: from device `__continue`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse when the sweep completes.
- `vec_cnt` out W+1: operands processed, including skipped ones.
- `skip_cnt` out W+1: operands skipped because the divisor was zero.
- `err_cnt` out W+1: mismatches.
- `first_bad_valid` out 1: high once the first mismatch is recorded.
- `first_bad_x` out W: operand of the first mismatch.

## Operation
- State machine: IDLE → DRIVE → MUL1 → MUL2 → DIV1 → DIV2 → CMP → (DRIVE | FINISH) → IDLE.
- **IDLE**
  - An accepted `start` loads `x` ← `x_first` and `last` ← `x_last`.
  - It clears all counters and `first_bad_*`, then enters DRIVE.
- **DRIVE**
  - `dut_in` ← `x`; it holds that value until the next DRIVE.
  - Latches `a` = x+1 and `d` = x−2, both mod 2^W.
- **MUL1**
  - `p` = a·a mod 2^W.
  - Shift-add, one multiplier bit per cycle, W cycles.
- **MUL2**
  - `m` = p·d mod 2^W.
  - Shift-add, W cycles.
- **DIV1**
  - `q` = m / 3, unsigned.
  - Restoring division, one quotient bit per cycle, W cycles.
- **DIV2**
  - `r` = q mod a.
  - Restoring division, W cycles.
  - If `a`==0 (x = 2^W−1), the result is undefined: the divider still runs, but its result is discarded.
- **CMP**
  - `vec_cnt`++.
  - If `a`==0: `skip_cnt`++ and no comparison.
  - Otherwise it is a mismatch when `dut_cont`==0 or `dut_out`≠`r`. On a mismatch, `err_cnt`++. On the first mismatch only, it captures `first_bad_x` ← `x` and sets `first_bad_valid`.
  - If `x`==`last`, go to FINISH. Otherwise `x` ← x+1 mod 2^W and go to DRIVE.
  - The sweep wraps through 2^W−1 to 0. `x_first`==`x_last` gives exactly one operand. A full wrap (`x_last` = `x_first`−1) gives 2^W operands, which is why the counters are W+1 bits.
- **FINISH**: `done` = 1 for one cycle, `busy` = 0, then IDLE.
- Counters never saturate; the maximum count is 2^W.
- `start` is ignored in every state other than IDLE.
- Reset values: all outputs 0 (`dut_in` = 0, `busy` = 0, `done` = 0, counters 0, `first_bad_*` 0). The state machine is in IDLE.
- Reset mid-sweep abandons the sweep immediately; no `done` is produced.

## Timing
- The device is combinational from `__in0` to `__out0`/`__continue`. `dut_out` is sampled in CMP, 4W+1 cycles after `dut_in` changes.
- Per operand: DRIVE 1 + 4·W + CMP 1 = 34 cycles at W=8.
- Sweep of N operands: N·34 cycles from the first DRIVE. FINISH follows the last CMP.
- `start` accepted in cycle t → DRIVE in t+1 and `busy` = 1 in t+1.
- Counters update at the end of CMP and are visible in the next cycle, before `done`.

## Structure
- Shared package `word_arith_pkg`:
  - width constant `W`;
  - state enum `wa_state_t`;
  - constant `DIV_CONST` = 3;
  - pure function `wa_ref(x)`, used by the bench only.
- One sub-module `wa_seq_divider`: W-cycle unsigned restoring divider with `start`/`done` and quotient/remainder outputs, used for both DIV1 and DIV2.
- The multiplier is inline (two registers and an adder).

## Test plan
- **Single operand**: `x_first`=`x_last`=7 with a correct device (f(7)=5) → `vec_cnt`=1, `err_cnt`=0, `done` 35 cycles after `start`.
- **Known values**: f(0)=0, f(1)=0, f(2)=0, f(3)=1, f(5)=0, f(10)=0; sweep 0..10 → `vec_cnt`=11, `err_cnt`=0.
- **Divide-by-zero skip**: sweep 250..255 → `skip_cnt`=1, `vec_cnt`=6, and x=255 never counts as an error even with `dut_out`=X.
- **Fault injection**: force `dut_out` = expected^1 at x=3 and x=9 in sweep 0..15 → `err_cnt`=2, `first_bad_x`=3. Separately, force `dut_cont`=0 at x=4 → counted as an error.
- **Wrap and full sweep**:
  - sweep 254..1 → operands 254, 255, 0, 1; `vec_cnt`=4.
  - sweep 0..255 → `vec_cnt`=256, `skip_cnt`=1.
  - both are checked against `wa_ref`.
- **Control edge cases**:
  - `start` pulsed while `busy` → ignored.
  - reset asserted mid-DIV1 → all outputs 0 next cycle and no `done`.
  - new `start` after reset → clean sweep.

Source files
------------

// File: rtl/word_arith_pkg.sv
// Shared width, state encoding and reference function for the word-arithmetic host.
// f(x) = ((((x+1)**2) * (x-2)) / 3) % (x+1), all values wrapping at W bits.
package word_arith_pkg;

   localparam int W     = 8;
   localparam int CNT_W = $clog2(W);

   localparam logic [W-1:0]     DIV_CONST = W'(3);
   localparam logic [W-1:0]     ONE_W     = W'(1);
   localparam logic [W-1:0]     TWO_W     = W'(2);
   localparam logic [W:0]       ONE_C     = (W+1)'(1);
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(W-1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DRIVE  = 3'd1,
      ST_MUL1   = 3'd2,
      ST_MUL2   = 3'd3,
      ST_DIV1   = 3'd4,
      ST_DIV2   = 3'd5,
      ST_CMP    = 3'd6,
      ST_FINISH = 3'd7
   } wa_state_t;

   function automatic logic [W-1:0] wa_ref(input logic [W-1:0] x);
      logic [W-1:0] a;
      logic [W-1:0] p;
      logic [W-1:0] m;
      logic [W-1:0] q;
      logic [W-1:0] r;
      a = x + ONE_W;
      p = a * a;
      m = p * (x - TWO_W);
      q = m / DIV_CONST;
      if (a == '0) begin
         r = '0;
      end else begin
         r = q % a;
      end
      return r;
   endfunction

endpackage

// File: rtl/word_arith_host_if.sv
// Host-side bundle: sweep control, device stimulus/response and result counters.
interface word_arith_host_if;
   import word_arith_pkg::*;

   logic         start;
   logic [W-1:0] x_first;
   logic [W-1:0] x_last;
   logic [W-1:0] dut_in;
   logic [W-1:0] dut_out;
   logic         dut_cont;
   logic         busy;
   logic         done;
   logic [W:0]   vec_cnt;
   logic [W:0]   skip_cnt;
   logic [W:0]   err_cnt;
   logic         first_bad_valid;
   logic [W-1:0] first_bad_x;

   modport master (
      input  start, x_first, x_last, dut_out, dut_cont,
      output dut_in, busy, done, vec_cnt, skip_cnt, err_cnt, first_bad_valid, first_bad_x
   );

   modport slave (
      output start, x_first, x_last, dut_out, dut_cont,
      input  dut_in, busy, done, vec_cnt, skip_cnt, err_cnt, first_bad_valid, first_bad_x
   );

endinterface

// File: rtl/wa_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; the first step runs in the start cycle,
// so quotient/remainder and the done pulse appear W cycles after start.
module wa_seq_divider
   import word_arith_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder,
   output logic         done
);

   logic [W-1:0]     rem_r;
   logic [W-1:0]     quo_r;
   logic [W-1:0]     div_r;
   logic [CNT_W-1:0] cnt_r;
   logic             busy_r;
   logic             done_r;

   logic [W-1:0]     rem_src_s;
   logic [W-1:0]     quo_src_s;
   logic [W-1:0]     div_src_s;
   logic [CNT_W-1:0] idx_s;
   logic [W:0]       shift_s;
   logic [W:0]       diff_s;
   logic [W-1:0]     rem_nxt_s;
   logic             qbit_s;
   logic             active_s;
   logic             last_s;

   // One restoring step on either freshly loaded operands or the running state.
   always_comb begin
      rem_src_s = start ? '0 : rem_r;
      quo_src_s = start ? dividend : quo_r;
      div_src_s = start ? divisor : div_r;
      idx_s     = start ? '0 : cnt_r;
      shift_s   = {rem_src_s, quo_src_s[W-1]};
      diff_s    = shift_s - {1'b0, div_src_s};
      active_s  = start | busy_r;
      last_s    = (idx_s == LAST_BIT);
      if (shift_s >= {1'b0, div_src_s}) begin
         rem_nxt_s = diff_s[W-1:0];
         qbit_s    = 1'b1;
      end else begin
         rem_nxt_s = shift_s[W-1:0];
         qbit_s    = 1'b0;
      end
   end

   // Divider state: partial remainder, dividend/quotient shift register, step counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem_r  <= '0;
         quo_r  <= '0;
         div_r  <= '0;
         cnt_r  <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else if (active_s) begin
         rem_r  <= rem_nxt_s;
         quo_r  <= {quo_src_s[W-2:0], qbit_s};
         div_r  <= div_src_s;
         cnt_r  <= last_s ? '0 : idx_s + CNT_W'(1);
         busy_r <= !last_s;
         done_r <= last_s;
      end else begin
         done_r <= 1'b0;
      end
   end

   assign quotient  = quo_r;
   assign remainder = rem_r;
   assign done      = done_r;

endmodule

// File: rtl/word_arith_host.sv
// Sweeps operands into the word-arithmetic device and checks each response against
// a locally computed f(x) built from a shift/add multiplier and a restoring divider.
module word_arith_host
   import word_arith_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   word_arith_host_if.master bus
);

   wa_state_t        state_r, state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [W-1:0]     x_r, last_r, a_r, d_r;
   logic [W-1:0]     acc_r, mc_r, mp_r;
   logic [W-1:0]     dut_in_r, fb_x_r;
   logic [W:0]       vec_r, skip_r, err_r;
   logic             fb_valid_r, busy_r, done_r;
   logic             busy_nxt_s, done_nxt_s;

   logic [W-1:0]     acc_sum_s;
   logic             phase_end_s;
   logic             mismatch_s;
   logic             div_start_s, div_done_s;
   logic [W-1:0]     div_dividend_s, div_divisor_s, div_quo_s, div_rem_s;

   wa_seq_divider u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start_s),
      .dividend  (div_dividend_s),
      .divisor   (div_divisor_s),
      .quotient  (div_quo_s),
      .remainder (div_rem_s),
      .done      (div_done_s)
   );

   // Multiplier adder, phase end, device check and divider operand selection.
   always_comb begin
      acc_sum_s   = acc_r + (mp_r[0] ? mc_r : '0);
      phase_end_s = (cnt_r == LAST_BIT);
      mismatch_s  = !bus.dut_cont || (bus.dut_out != div_rem_s);
      // DIV2 is launched by DIV1's done pulse so it divides the settled quotient.
      if (state_r == ST_DIV1) begin
         div_start_s    = (cnt_r == '0);
         div_dividend_s = acc_r;
         div_divisor_s  = DIV_CONST;
      end else begin
         div_start_s    = (state_r == ST_DIV2) && div_done_s;
         div_dividend_s = div_quo_s;
         div_divisor_s  = a_r;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE:   if (bus.start) state_nxt_s = ST_DRIVE; else state_nxt_s = ST_IDLE;
         ST_DRIVE:  state_nxt_s = ST_MUL1;
         ST_MUL1:   if (phase_end_s) state_nxt_s = ST_MUL2; else state_nxt_s = ST_MUL1;
         ST_MUL2:   if (phase_end_s) state_nxt_s = ST_DIV1; else state_nxt_s = ST_MUL2;
         ST_DIV1:   if (phase_end_s) state_nxt_s = ST_DIV2; else state_nxt_s = ST_DIV1;
         ST_DIV2:   if (phase_end_s) state_nxt_s = ST_CMP; else state_nxt_s = ST_DIV2;
         ST_CMP:    if (x_r == last_r) state_nxt_s = ST_FINISH; else state_nxt_s = ST_DRIVE;
         ST_FINISH: state_nxt_s = ST_IDLE;
         default:   state_nxt_s = ST_IDLE;
      endcase
   end

   // Output decode from the next state, registered below so busy/done track the state exactly.
   always_comb begin
      busy_nxt_s = 1'b0;
      done_nxt_s = 1'b0;
      case (state_nxt_s)
         ST_IDLE:   busy_nxt_s = 1'b0;
         ST_FINISH: done_nxt_s = 1'b1;
         default:   busy_nxt_s = 1'b1;
      endcase
   end

   // Registered status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= busy_nxt_s;
         done_r <= done_nxt_s;
      end
   end

   // Operand sequencing, multiplier datapath and result tallies.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r      <= '0;
         x_r        <= '0;
         last_r     <= '0;
         a_r        <= '0;
         d_r        <= '0;
         acc_r      <= '0;
         mc_r       <= '0;
         mp_r       <= '0;
         dut_in_r   <= '0;
         vec_r      <= '0;
         skip_r     <= '0;
         err_r      <= '0;
         fb_valid_r <= 1'b0;
         fb_x_r     <= '0;
      end else begin
         if (state_r inside {ST_MUL1, ST_MUL2, ST_DIV1, ST_DIV2}) begin
            cnt_r <= phase_end_s ? '0 : cnt_r + CNT_W'(1);
         end else begin
            cnt_r <= '0;
         end
         case (state_r)
            ST_IDLE: begin
               if (bus.start) begin
                  x_r        <= bus.x_first;
                  last_r     <= bus.x_last;
                  vec_r      <= '0;
                  skip_r     <= '0;
                  err_r      <= '0;
                  fb_valid_r <= 1'b0;
                  fb_x_r     <= '0;
               end
            end
            ST_DRIVE: begin
               dut_in_r <= x_r;
               a_r      <= x_r + ONE_W;
               d_r      <= x_r - TWO_W;
               acc_r    <= '0;
               mc_r     <= x_r + ONE_W;
               mp_r     <= x_r + ONE_W;
            end
            ST_MUL1: begin
               // On the last bit, p becomes the multiplier of the second product.
               if (phase_end_s) begin
                  acc_r <= '0;
                  mc_r  <= d_r;
                  mp_r  <= acc_sum_s;
               end else begin
                  acc_r <= acc_sum_s;
                  mc_r  <= {mc_r[W-2:0], 1'b0};
                  mp_r  <= {1'b0, mp_r[W-1:1]};
               end
            end
            ST_MUL2: begin
               acc_r <= acc_sum_s;
               mc_r  <= {mc_r[W-2:0], 1'b0};
               mp_r  <= {1'b0, mp_r[W-1:1]};
            end
            ST_CMP: begin
               vec_r <= vec_r + ONE_C;
               if (a_r == '0) begin
                  skip_r <= skip_r + ONE_C;
               end else if (mismatch_s) begin
                  err_r <= err_r + ONE_C;
                  if (!fb_valid_r) begin
                     fb_valid_r <= 1'b1;
                     fb_x_r     <= x_r;
                  end
               end
               if (x_r != last_r) begin
                  x_r <= x_r + ONE_W;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.dut_in          = dut_in_r;
   assign bus.busy            = busy_r;
   assign bus.done            = done_r;
   assign bus.vec_cnt         = vec_r;
   assign bus.skip_cnt        = skip_r;
   assign bus.err_cnt         = err_r;
   assign bus.first_bad_valid = fb_valid_r;
   assign bus.first_bad_x     = fb_x_r;

endmodule
